// File: rtl/cache_refill_controller_pkg.sv
// Shared widths, derived field sizes and FSM encoding for the cache refill controller.
package cache_refill_controller_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int TAG_WIDTH    = 24;
    localparam int OFFSET_WIDTH = 4;
    localparam int LINE_WIDTH   = 128;
    localparam int NUM_WAYS     = 4;

    localparam int WAY_BITS  = $clog2(NUM_WAYS);
    localparam int IDX_WIDTH = ADDR_WIDTH - TAG_WIDTH - OFFSET_WIDTH;

    // Clears the byte-offset bits so memory always sees a line-aligned address.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFFSET_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        FILL     = 2'd3
    } state_t;

endpackage

// File: rtl/cache_refill_controller_victim_selector.sv
// Victim way choice: lowest invalid way first, otherwise a round-robin pointer that
// only moves when a pointer-chosen victim is actually filled.
module cache_refill_controller_victim_selector
    import cache_refill_controller_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic                advance,
    output logic [WAY_BITS-1:0] victim_way
);

    logic [WAY_BITS-1:0] rr_ptr;
    logic                invalid_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (rr_ptr == WAY_BITS'(NUM_WAYS - 1)) ? '0 : rr_ptr + WAY_BITS'(1);
        end
    end

    always_comb begin
        victim_way    = rr_ptr;
        invalid_found = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!invalid_found && !valid_vec[i]) begin
                victim_way    = WAY_BITS'(i);
                invalid_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_refill_controller.sv
// Lookup/refill sequencer: one access at a time, hit returns the way, miss fetches,
// fills a victim and re-looks-up. Optional statistics under macro CACHE_STATS_EN.
module cache_refill_controller
    import cache_refill_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic [TAG_WIDTH-1:0]  lookup_tag,
    output logic [IDX_WIDTH-1:0]  lookup_index,
    input  logic [NUM_WAYS-1:0]   hit_vec,
    input  logic [NUM_WAYS-1:0]   valid_vec,
    output logic                  resp_valid,
    output logic [WAY_BITS-1:0]   resp_way,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_data_valid,
    input  logic [LINE_WIDTH-1:0] mem_data,
    output logic                  fill_en,
    output logic [WAY_BITS-1:0]   fill_way,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    state_t                state;
    state_t                state_next;
    logic                  lookup_hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic                  hit_found;
    logic [WAY_BITS-1:0]   victim_way;
    logic [WAY_BITS-1:0]   victim_q;
    logic                  victim_from_ptr;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] line_addr;

    assign lookup_hit = |hit_vec;
    assign line_addr  = req_addr & LINE_MASK;

    always_comb begin
        hit_way   = '0;
        hit_found = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!hit_found && hit_vec[i]) begin
                hit_way   = WAY_BITS'(i);
                hit_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        fill_en    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                state_next = lookup_hit ? IDLE : MEM_WAIT;
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_data_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                fill_en    = 1'b1;
                state_next = LOOKUP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Response is registered, so it appears the cycle after LOOKUP, with the FSM already idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_tag      <= '0;
            lookup_index    <= '0;
            mem_addr        <= '0;
            resp_valid      <= 1'b0;
            resp_way        <= '0;
            victim_q        <= '0;
            victim_from_ptr <= 1'b0;
            fill_data       <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lookup_tag   <= req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                        lookup_index <= req_addr[OFFSET_WIDTH +: IDX_WIDTH];
                        mem_addr     <= line_addr;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        resp_valid <= 1'b1;
                        resp_way   <= hit_way;
                    end else begin
                        victim_q        <= victim_way;
                        victim_from_ptr <= &valid_vec;
                    end
                end
                MEM_WAIT: begin
                    if (mem_data_valid) begin
                        fill_data <= mem_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fill_way = victim_q;
    assign advance  = (state == FILL) && victim_from_ptr;

    cache_refill_controller_victim_selector victim_selector (
        .clk        (clk),
        .reset      (reset),
        .valid_vec  (valid_vec),
        .advance    (advance),
        .victim_way (victim_way)
    );

`ifdef CACHE_STATS_EN
    logic        first_lookup;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Only the first lookup of an access counts; the post-fill re-lookup is excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_lookup <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                first_lookup <= 1'b1;
            end else if (state == LOOKUP) begin
                first_lookup <= 1'b0;
            end
            if (state == LOOKUP && first_lookup) begin
                if (lookup_hit) begin
                    if (hit_cnt_q != 32'hFFFF_FFFF) begin
                        hit_cnt_q <= hit_cnt_q + 32'd1;
                    end
                end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
